posit_decode_pipe: RTL
======================

Name: posit_decode_pipe

Overview:
- Two-stage pipelined posit decoder with a valid/ready stream interface.
- Splits a BITS-wide posit word into sign, regime value k, exponent, left-aligned fraction, combined scale, and zero/NaR flags.
- Successor to the combinational regime/seed extraction logic. Adds a parametrised exponent field (ES), negative-input handling, special-value detection and backpressure.
- Feeds the posit arithmetic datapath (mul/add/sqrt seed stages).

Parameters:
- BITS, 32: posit word width, >= 8.
- ES, 2: exponent field width, 0..4.
- KW, $clog2(BITS)+1: signed width of the regime value k (derived).
- SW, KW+ES: signed width of the scale (derived).
- FW, BITS-3-ES: fraction width, hidden bit excluded (derived).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  BITS  posit word.
- out_valid  out  1  output fields are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_sign  out  1  sign bit of the posit.
- out_k  out  KW  signed regime value.
- out_exp  out  ES  exponent field; width 1, tied 0 when ES=0.
- out_scale  out  SW  signed scale, k*2^ES + exp.
- out_frac  out  FW  fraction, MSB-aligned, zero-padded.
- out_zero  out  1  input was 0.
- out_nar  out  1  input was NaR (1 followed by all 0s).

Behaviour:
- Reset (async, rst_n=0): both stage valid bits are 0 and out_valid=0 immediately. All data registers and outputs are 0. in_ready=1 combinationally after reset, since the pipe is empty.
- Pipeline advance rules:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv.
  - A transfer occurs on a cycle where valid & ready are both high.
- Latency: 2 cycles from input accept to out_valid with out_ready held high. Throughput is 1 word per cycle.
- While out_valid=1 and out_ready=0, all out_* are held stable. No combinational path exists from in_* to out_*.
- Stage 1, captured on in accept:
  - sign = in_data[BITS-1].
  - mag = sign ? -in_data : in_data, two's complement, BITS wide.
  - zero = (in_data==0); nar = (in_data == 1<<(BITS-1)).
- Stage 2, captured on s1->s2 transfer:
  - r = mag[BITS-2]. m = length of the run of bits equal to r, starting at mag[BITS-2] and going downward, capped at BITS-1.
  - k = -m when r=0; k = m-1 when r=1.
  - Terminating bit: consumed when the run ends before bit 0; otherwise absent.
  - Remaining bits are shifted left. The top ES bits form exp; bits past the LSB read as 0. The next FW bits form frac, zero-padded.
  - scale = (k <<< ES) + exp, computed in SW bits with sign extension of k.
  - When zero or nar: k=0, exp=0, frac=0, scale=0, and the corresponding flag is 1. out_sign=1 for NaR, 0 for zero.
- Width rules: KW holds ±(BITS-1); SW holds ±((BITS-2)<<ES)+2^ES-1. No saturation is needed.
- Simultaneous events: a stage may load new data in the same cycle its old data moves on. A full pipe with out_ready=1 accepts a new input every cycle.
- Reset mid-operation: all in-flight words are discarded. Nothing is emitted for them after reset deasserts.

Test Plan (BITS=32, ES=2, out_ready=1 unless stated):
- in 0x40000000 -> 2 cycles later: sign=0, k=0, exp=0, scale=0, frac=0, zero=0, nar=0.
- in 0x48000000 -> k=0, exp=1, scale=1, frac=0. in 0xC0000000 -> sign=1, k=0, scale=0 (value -1.0).
- in 0x7FFFFFFF -> k=30, exp=0, scale=120, frac=0. in 0x00000001 -> k=-30, scale=-120. in 0x00000000 -> zero=1. in 0x80000000 -> nar=1, sign=1, scale=0.
- Backpressure:
  - Stimulus: out_ready=0; offer 0x40000000, 0x48000000, 0x7FFFFFFF back to back.
  - Response: exactly 2 are accepted and in_ready=0 on the 3rd. Outputs hold the 1.0 decode unchanged.
  - Then raise out_ready: the 3 results emerge in order, 1 per cycle.
- Streaming: 100 random words with random in_valid/out_ready -> output sequence matches a reference-model decode in order, with no drops or duplicates.
- Reset: with 2 words in flight, pulse rst_n low mid-cycle -> out_valid=0 asynchronously. After release, no stale output appears and in_ready=1.

Source files
------------

// File: rtl/posit_decode_if.sv
// Stream interface for the posit decoder: valid/ready input word in,
// valid/ready decoded fields out.
interface posit_decode_if #(
    parameter int BITS = 32,
    parameter int ES   = 2
);
    localparam int KW = $clog2(BITS) + 1;
    localparam int SW = KW + ES;
    localparam int FW = BITS - 3 - ES;
    localparam int EW = (ES == 0) ? 1 : ES;

    logic                 in_valid;
    logic                 in_ready;
    logic [BITS-1:0]      in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_sign;
    logic signed [KW-1:0] out_k;
    logic [EW-1:0]        out_exp;
    logic signed [SW-1:0] out_scale;
    logic [FW-1:0]        out_frac;
    logic                 out_zero;
    logic                 out_nar;

    // Producer of words / consumer of decodes.
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sign, out_k, out_exp,
               out_scale, out_frac, out_zero, out_nar
    );

    // The decoder itself.
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sign, out_k, out_exp,
               out_scale, out_frac, out_zero, out_nar
    );
endinterface

// File: rtl/posit_decode_pipe.sv
// Two-stage posit decoder. Stage 1 takes the magnitude and flags specials,
// stage 2 splits regime / exponent / fraction and forms the scale.
module posit_decode_pipe #(
    parameter int BITS = 32,
    parameter int ES   = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    posit_decode_if.slave  bus
);
    localparam int KW = $clog2(BITS) + 1;
    localparam int SW = KW + ES;
    localparam int FW = BITS - 3 - ES;
    localparam int EW = (ES == 0) ? 1 : ES;
    localparam int RW = BITS - 3;            // bits left after sign, min regime, terminator
    localparam int AW = $clog2(BITS - 1);

    logic                 s1_vld_q, s2_vld_q;
    logic                 s1_adv, s2_adv;
    logic                 s1_sign_q, s1_zero_q, s1_nar_q;
    logic [BITS-2:0]      s1_mag_q;          // magnitude of a non-NaR word never sets the MSB
    logic [BITS-2:0]      mag_d;

    logic                 s2_sign_q, s2_zero_q, s2_nar_q;
    logic signed [KW-1:0] s2_k_q, k_d;
    logic [EW-1:0]        s2_exp_q, exp_d;
    logic signed [SW-1:0] s2_scale_q, scale_d;
    logic [FW-1:0]        s2_frac_q, frac_d;
    logic [RW-1:0]        rem;

    // A stage may take new data whenever it is empty or its contents move on.
    assign s2_adv       = !s2_vld_q || bus.out_ready;
    assign s1_adv       = !s1_vld_q || s2_adv;
    assign bus.in_ready = s1_adv;

    // Two's-complement negate on the low bits; NaR wraps to 0 and is flagged.
    assign mag_d = bus.in_data[BITS-1] ? (~bus.in_data[BITS-2:0] + 1'b1)
                                       : bus.in_data[BITS-2:0];

    // Stage 1: capture sign, magnitude and special-value flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_zero_q <= 1'b0;
            s1_nar_q  <= 1'b0;
            s1_mag_q  <= '0;
        end else if (s1_adv) begin
            s1_vld_q <= bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_q <= bus.in_data[BITS-1];
                s1_zero_q <= (bus.in_data == '0);
                s1_nar_q  <= (bus.in_data == {1'b1, {(BITS-1){1'b0}}});
                s1_mag_q  <= mag_d;
            end
        end
    end

    // Regime run-length, then left-align what follows the terminator.
    always_comb begin
        logic r, run;
        int   m, shift, idx, kv;
        logic signed [SW-1:0] kx;
        r   = s1_mag_q[BITS-2];
        run = 1'b1;
        m   = 0;
        for (int i = BITS - 2; i >= 0; i--) begin
            if (run && (s1_mag_q[i] == r)) m = m + 1;
            else run = 1'b0;
        end
        // consumed: sign + run + terminator (absent when the run hits bit 0)
        shift = 1 + m + ((m < BITS - 1) ? 1 : 0);
        rem = '0;
        for (int j = 0; j < RW; j++) begin
            idx = BITS - 1 - shift - j;
            if (idx >= 0) rem[RW-1-j] = s1_mag_q[idx[AW-1:0]];
        end
        kv      = r ? (m - 1) : -m;
        k_d     = KW'(kv);
        exp_d   = (ES == 0) ? '0 : rem[RW-1 -: EW];
        frac_d  = rem[FW-1:0];
        kx      = SW'(k_d);
        scale_d = SW'(kx <<< ES) + SW'(exp_d);
    end

    // Stage 2: register decoded fields; specials force the numeric fields to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q   <= 1'b0;
            s2_sign_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_nar_q   <= 1'b0;
            s2_k_q     <= '0;
            s2_exp_q   <= '0;
            s2_scale_q <= '0;
            s2_frac_q  <= '0;
        end else if (s2_adv) begin
            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_sign_q <= s1_sign_q;
                s2_zero_q <= s1_zero_q;
                s2_nar_q  <= s1_nar_q;
                if (s1_zero_q || s1_nar_q) begin
                    s2_k_q     <= '0;
                    s2_exp_q   <= '0;
                    s2_scale_q <= '0;
                    s2_frac_q  <= '0;
                end else begin
                    s2_k_q     <= k_d;
                    s2_exp_q   <= exp_d;
                    s2_scale_q <= scale_d;
                    s2_frac_q  <= frac_d;
                end
            end
        end
    end

    assign bus.out_valid = s2_vld_q;
    assign bus.out_sign  = s2_sign_q;
    assign bus.out_k     = s2_k_q;
    assign bus.out_exp   = s2_exp_q;
    assign bus.out_scale = s2_scale_q;
    assign bus.out_frac  = s2_frac_q;
    assign bus.out_zero  = s2_zero_q;
    assign bus.out_nar   = s2_nar_q;
endmodule
